// File: rtl/replica_pkg.sv
// replica_pkg: shared replica/city sizing and the collector output word layout
package replica_pkg;
  localparam int city_num = 8;
  localparam int city_num_log = 3;
  localparam int node_num = 4;
  localparam int node_log = 2;
  typedef struct packed {
    logic [node_log-1:0] replica;
    logic [city_num_log-1:0] pos;
    logic [city_num_log-1:0] city;
  } ord_word_t;
endpackage

// File: rtl/collector_fifo.sv
// collector_fifo: power-of-two skid FIFO; writes when full and reads when empty are ignored
module collector_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
  always_ff @(posedge clk) if (do_wr) mem[wp] <= wdata;
endmodule

// File: rtl/ordering_collector.sv
// ordering_collector: credit-paced readout of replica orderings into a tagged host stream
module ordering_collector
  import replica_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NODES = node_num,
  parameter int CITIES = city_num
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                shift_cmd,
  input  logic                                ord_valid,
  input  logic [city_num_log-1:0]             ord_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [node_log+2*city_num_log-1:0]  m_data,
  output logic                                m_last,
  output logic                                busy,
  output logic                                done,
  output logic                                err_ovf,
  output logic                                err_unexp
);
  localparam int TOTAL = NODES * CITIES;
  localparam int TW = $clog2(TOTAL + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE_S = 2'd3;
  logic [1:0] state;
  logic [TW-1:0] issued, received, outst;
  logic [node_log-1:0] rep;
  logic [city_num_log-1:0] pos;
  logic last_seen, active, pop, credit_ok, pos_end;
  logic [CW-1:0] f_count;
  logic f_full, f_empty;
  logic [city_num_log-1:0] f_rdata;
  ord_word_t word;
  collector_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(city_num_log)) u_fifo (
    .clk(clk), .reset(reset), .wr(ord_valid & active), .wdata(ord_data), .rd(pop),
    .rdata(f_rdata), .count(f_count), .full(f_full), .empty(f_empty)
  );
  assign active = state == RUN || state == DRAIN;
  assign busy = active;
  assign done = state == DONE_S;
  assign m_valid = ~f_empty;
  assign pop = m_valid & m_ready;
  // a stray extra word can push received past issued; treat that as nothing outstanding
  assign outst = issued > received ? issued - received : '0;
  assign credit_ok = int'(f_count) + int'(outst) < FIFO_DEPTH;
  assign shift_cmd = state == RUN && credit_ok && issued < TW'(TOTAL);
  assign pos_end = pos == city_num_log'(CITIES - 1);
  assign m_last = m_valid && pos_end && rep == node_log'(NODES - 1);
  assign word = '{replica: rep, pos: pos, city: f_rdata};
  assign m_data = word;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      issued <= '0;
      received <= '0;
      rep <= '0;
      pos <= '0;
      last_seen <= 1'b0;
      err_ovf <= 1'b0;
      err_unexp <= 1'b0;
    end else if (state == IDLE && start) begin
      state <= RUN;
      issued <= '0;
      received <= '0;
      rep <= '0;
      pos <= '0;
      last_seen <= 1'b0;
      err_ovf <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      if (shift_cmd) issued <= issued + 1'b1;
      if (ord_valid && active) received <= received + 1'b1;
      if (ord_valid && active && f_full) err_ovf <= 1'b1;
      if (ord_valid && !active) err_unexp <= 1'b1;
      if (pop) pos <= pos_end ? '0 : pos + 1'b1;
      if (pop && pos_end) rep <= rep + 1'b1;
      if (pop && m_last) last_seen <= 1'b1;
      state <= (state == RUN && shift_cmd && issued == TW'(TOTAL - 1)) ? DRAIN :
               (state == DRAIN && last_seen && received >= TW'(TOTAL) && f_empty) ? DONE_S :
               (state == DONE_S) ? IDLE : state;
    end
  end
endmodule

// File: doc/ordering_collector.md
ORDERING_COLLECTOR -- requirements
Module: ordering_collector

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: skid FIFO entries; power of two, at least 2.
REQ-002 Parameter NODES, default node_num (package): replicas read per run.
REQ-003 Parameter CITIES, default city_num (package): ordering words per replica.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  reset is asynchronous and active-high.
REQ-006 start  in  1  one-cycle run request; honoured only in IDLE.
REQ-007 shift_cmd  out  1  one-cycle pulse to the chain's exchange_shift_d; requests one ordering word.
REQ-008 ord_valid  in  1  word returned from the chain's last out_ord_valid; no backpressure possible.
REQ-009 ord_data  in  city_num_log  city index carried by that word.
REQ-010 m_valid / m_ready  out / in  1 / 1  host stream handshake; transfer when both high.
REQ-011 m_data  out  node_log+2*city_num_log  {replica index, position index, city index}.
REQ-012 m_last  out  1  high with the final word of a run.
REQ-013 busy  out  1  high in RUN and DRAIN.
REQ-014 done  out  1  one-cycle pulse at run completion.
REQ-015 err_ovf / err_unexp  out  1 / 1  sticky errors; cleared only by reset or an accepted start.

Function
REQ-016 States: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start -> RUN; clears issue, receive and output counters and both error flags.
REQ-018 RUN: shift_cmd pulses when credit > 0 and issued < NODES*CITIES; each pulse increments issued and consumes one credit.
REQ-019 Credit: FIFO_DEPTH - fifo_count - outstanding; outstanding = issued - received; shift_cmd never issues with zero credit.
REQ-020 RUN -> DRAIN in the cycle after the last shift_cmd.
REQ-021 DRAIN -> DONE when received = NODES*CITIES, FIFO empty and the m_last transfer completes.
REQ-022 DONE: done high for exactly one cycle, then IDLE.
REQ-023 ord_valid in RUN/DRAIN writes ord_data to the FIFO and increments received.
REQ-024 ord_valid with the FIFO full: word dropped, err_ovf set, received still increments.
REQ-025 ord_valid in IDLE or DONE: word dropped, err_unexp set.
REQ-026 Simultaneous FIFO write and read: both happen; occupancy unchanged.
REQ-027 m_valid = FIFO not empty, combinational from FIFO state; head word is stable while m_valid is high and m_ready is low.
REQ-028 Replica and position indices come from the output counter; position wraps CITIES-1 -> 0 and then increments replica; m_last when replica = NODES-1 and position = CITIES-1.
REQ-029 start outside IDLE is ignored.
REQ-030 Minimum latency: first shift_cmd in the cycle after start is accepted.

Reset
REQ-031 Asynchronous reset takes effect immediately in any state. Afterwards: state = IDLE, FIFO empty, all counters 0, and shift_cmd, m_valid, m_last, busy, done, err_ovf, err_unexp all 0.
REQ-032 Reset during RUN or DRAIN abandons the run; words arriving after reset release set err_unexp.

Structure
REQ-033 city_num, city_num_log, node_num and node_log belong in replica_pkg; the module defines no local copies.
REQ-034 The state enum is local to the module.
REQ-035 The FIFO is a separate sub-module, collector_fifo: parameterised depth and width, with count, full and empty outputs.

Verification
REQ-036 NODES=4, CITIES=8, m_ready tied 1, chain latency 3 -> 32 words; m_data positions 0..7 per replica 0..3; m_last on word 31; done exactly once; no error flags.
REQ-037 Same setup, m_ready held low for 20 cycles -> at most 4 shift_cmd outstanding; no err_ovf; data order preserved after release.
REQ-038 ord_valid injected in IDLE -> err_unexp=1; no m_valid; next start clears the flag.
REQ-039 Extra forced ord_valid while the FIFO is full -> err_ovf=1; that word is absent from the stream.
REQ-040 Reset asserted mid-RUN after 10 words -> all outputs 0 in the same cycle; a new start produces a full correct 32-word run.
REQ-041 start pulsed during RUN -> ignored; word count remains 32.
